// File: rtl/arb_pkg.sv
// Shared constants, state type and reset values for the rr_arbiter4 slice.
// Optional forced-release timeout is enabled with ARB_TIMEOUT_EN.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam arb_state_e       RST_STATE = IDLE;
    localparam logic [IDX_W-1:0] RST_PTR   = '0;
    localparam logic [IDX_W-1:0] RST_IDX   = '0;
    localparam logic [7:0]       RST_HOLD  = '0;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request scanning
// ptr, ptr+1, ... modulo NUM_REQ.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Scanning from the farthest offset down lets the nearest hit overwrite.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold and release handshake.
// ARB_TIMEOUT_EN adds a forced release after MAX_HOLD cycles in GRANT.
// The handshake input is release_in because "release" is a reserved word.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic                CLK,
    input  logic                Reset_L,
    input  logic [3:0]          req,
    input  logic                release_in,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid,
    output logic                timeout_pulse,
    output logic                dbg_state
);

    if (NUM_REQ != arb_pkg::NUM_REQ) begin : g_num_req_chk
        $error("rr_arbiter4: NUM_REQ must be 4");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_chk
        $error("rr_arbiter4: MAX_HOLD must be in 1..255");
    end

    // Handshake: a grant is owned while grant_valid=1; the holder ends it by
    // asserting release_in for one cycle. req and release_in are sampled on
    // the rising edge of CLK; all outputs come straight from flops.
    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_d        = hold_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                grant_valid_d = 1'b0;
                if (pick_any) begin
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    state_d       = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_d        = '0;
`endif
                end
            end
            GRANT: begin
                if (release_in) begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                    ptr_d         = grant_idx_q + 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                    ptr_d         = grant_idx_q + 1'b1;
                    timeout_d     = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q       <= RST_STATE;
            ptr_q         <= RST_PTR;
            grant_idx_q   <= RST_IDX;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            hold_q    <= RST_HOLD;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_pulse = timeout_q;
`else
    assign timeout_pulse = 1'b0;
`endif

    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed steps plus random traffic,
// compared each cycle against a behavioural round-robin model.
module tb_rr_arbiter4;

    localparam int TB_MAX_HOLD = 4;

    logic       CLK;
    logic       Reset_L;
    logic [3:0] req;
    logic       release_in;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout_pulse;
    logic       dbg_state;

    int n_tests;
    int n_fail;

    // Behavioural model: who owns the grant, how long it has been owned,
    // and which requester is first in line next time.
    int   m_owner;
    bit   m_owned;
    int   m_age;
    int   m_first;
    bit   m_timeout;

    int   exp_seq[5] = '{0, 1, 2, 3, 0};

    rr_arbiter4 #(
        .MAX_HOLD (TB_MAX_HOLD)
    ) dut (
        .CLK           (CLK),
        .Reset_L       (Reset_L),
        .req           (req),
        .release_in    (release_in),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .timeout_pulse (timeout_pulse),
        .dbg_state     (dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = 0;
        m_owned   = 0;
        m_age     = 0;
        m_first   = 0;
        m_timeout = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input bit rel);
        m_timeout = 0;
        if (!m_owned) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_owned && r[(m_first + k) % 4]) begin
                    m_owner = (m_first + k) % 4;
                    m_owned = 1;
                    m_age   = 1;
                end
            end
        end else if (rel) begin
            m_owned = 0;
            m_first = (m_owner + 1) % 4;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (m_age == TB_MAX_HOLD) begin
                m_owned   = 0;
                m_first   = (m_owner + 1) % 4;
                m_timeout = 1;
            end else begin
                m_age++;
            end
`else
            m_age++;
`endif
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   8'(grant_valid),   8'(m_owned));
        chk({tag, ".idx"},     8'(grant_idx),     8'(m_owner));
        chk({tag, ".timeout"}, 8'(timeout_pulse), 8'(m_timeout));
        chk({tag, ".state"},   8'(dbg_state),     8'(m_owned));
    endtask

    // Inputs change #1 after an edge; outputs are checked #1 after the next.
    task automatic cycle(input string tag, input logic [3:0] r, input bit rel);
        req        = r;
        release_in = rel;
        @(posedge CLK);
        model_edge(r, rel);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        Reset_L = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2;
        Reset_L = 1'b1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        Reset_L    = 1'b0;
        req        = '0;
        release_in = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge CLK);
        Reset_L = 1'b1;

        // Single requester, grant one cycle after sampling, then hold.
        cycle("req2_grant", 4'b0100, 1'b0);
        chk("req2_idx_const", 8'(grant_idx), 8'd2);
        for (int i = 0; i < 5; i++) cycle("req2_hold", 4'b0100, 1'b0);
        cycle("req2_release", 4'b0000, 1'b1);

        // Round-robin walk from ptr=0 with all requesting.
        do_reset("reset2");
        for (int g = 0; g < 5; g++) begin
            cycle("rr_grant", 4'b1111, 1'b0);
            chk("rr_seq", 8'(grant_idx), 8'(exp_seq[g]));
            cycle("rr_release", 4'b1111, 1'b1);
            chk("rr_gap", 8'(grant_valid), 8'd0);
        end

        // Grant at 3, release wraps ptr to 0.
        cycle("idx3_grant", 4'b1000, 1'b0);
        cycle("idx3_release", 4'b0000, 1'b1);
        cycle("wrap_grant", 4'b1001, 1'b0);
        chk("wrap_idx_const", 8'(grant_idx), 8'd0);
        cycle("wrap_release", 4'b0000, 1'b1);

        // Request drop does not revoke; release in IDLE ignored.
        cycle("drop_grant", 4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) cycle("drop_hold", 4'b0000, 1'b0);
        cycle("drop_release", 4'b0000, 1'b1);
        cycle("idle_release", 4'b0000, 1'b1);
        cycle("idle_release2", 4'b0000, 1'b1);

        // Lone requester regranted after its own release.
        cycle("lone_grant", 4'b0100, 1'b0);
        cycle("lone_release", 4'b0100, 1'b1);
        cycle("lone_regrant", 4'b0100, 1'b0);
        chk("lone_idx_const", 8'(grant_idx), 8'd2);
        cycle("lone_release2", 4'b0000, 1'b1);

        // Asynchronous reset mid-grant, arbitration restarts at ptr=0.
        cycle("mid_grant", 4'b0100, 1'b0);
        do_reset("mid_reset");
        cycle("post_reset", 4'b1110, 1'b0);
        chk("post_reset_const", 8'(grant_idx), 8'd1);

        // Long hold: forced release with the timeout build, held otherwise.
        for (int i = 0; i < 22; i++) cycle("long_hold", 4'b0000, 1'b0);
        cycle("long_release", 4'b0000, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("random", 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
